// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_controller
// Brief    : Multi-cycle control FSM that sequences the 16-bit RISC datapath.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] instr,
  output logic        ready,
  output logic        done,
  output logic        illegal,
  output logic [2:0]  r_addr,
  output logic        en_A,
  output logic        en_B,
  output logic        sel_A,
  output logic        sel_B,
  output logic [1:0]  shift_op,
  output logic [1:0]  ALU_op,
  output logic        en_C,
  output logic        en_status,
  output logic [1:0]  wb_sel,
  output logic [2:0]  w_addr,
  output logic        w_en,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_EXEC      = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  localparam logic [2:0] C_OPC_ALU  = 3'b101;
  localparam logic [2:0] C_OPC_MOV  = 3'b110;
  localparam logic [1:0] C_WB_C     = 2'b00;
  localparam logic [1:0] C_WB_IMM8  = 2'b10;

  state_t      r_state;
  state_t      w_nxt_state;
  logic [15:0] r_ir;

  logic [2:0]  w_opcode;
  logic [1:0]  w_op;
  logic [2:0]  w_rn;
  logic [2:0]  w_rd;
  logic [1:0]  w_sh;
  logic [2:0]  w_rm;

  logic        w_is_mov_imm;
  logic        w_is_mov_reg;
  logic        w_is_alu;
  logic        w_is_cmp;
  logic        w_is_mvn;
  logic        w_legal;
  logic        w_accept;

  logic        w_nxt_ready;
  logic        w_nxt_done;
  logic [2:0]  w_nxt_r_addr;
  logic        w_nxt_en_A;
  logic        w_nxt_en_B;
  logic        w_nxt_sel_A;
  logic [1:0]  w_nxt_shift_op;
  logic [1:0]  w_nxt_ALU_op;
  logic        w_nxt_en_C;
  logic        w_nxt_en_status;
  logic [1:0]  w_nxt_wb_sel;
  logic [2:0]  w_nxt_w_addr;
  logic        w_nxt_w_en;

  assign w_opcode = r_ir[15:13];
  assign w_op     = r_ir[12:11];
  assign w_rn     = r_ir[10:8];
  assign w_rd     = r_ir[7:5];
  assign w_sh     = r_ir[4:3];
  assign w_rm     = r_ir[2:0];

  assign w_is_mov_imm = (w_opcode == C_OPC_MOV) && (w_op == 2'b10);
  assign w_is_mov_reg = (w_opcode == C_OPC_MOV) && (w_op == 2'b00);
  assign w_is_alu     = (w_opcode == C_OPC_ALU);
  assign w_is_cmp     = w_is_alu && (w_op == 2'b01);
  assign w_is_mvn     = w_is_alu && (w_op == 2'b11);
  assign w_legal      = w_is_mov_imm || w_is_mov_reg || w_is_alu;

  assign w_accept = (r_state == S_IDLE) && start;

  assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
  assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};

  // The operand-B mux never selects its alternate input in this ISA.
  assign sel_B = 1'b0;

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE:      w_nxt_state = start ? S_DECODE : S_IDLE;
      S_DECODE: begin
        if (!w_legal)                      w_nxt_state = S_DONE;
        else if (w_is_mov_imm)             w_nxt_state = S_WRITE_IMM;
        else if (w_is_mov_reg || w_is_mvn) w_nxt_state = S_GET_B;
        else                               w_nxt_state = S_GET_A;
      end
      S_GET_A:     w_nxt_state = S_GET_B;
      S_GET_B:     w_nxt_state = S_EXEC;
      S_EXEC:      w_nxt_state = w_is_cmp ? S_DONE : S_WRITE_REG;
      S_WRITE_REG: w_nxt_state = S_DONE;
      S_WRITE_IMM: w_nxt_state = S_DONE;
      S_DONE:      w_nxt_state = S_IDLE;
      default:     w_nxt_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they register
  // alongside it and behave as clean Moore outputs of the current state.
  always_comb begin
    w_nxt_ready     = 1'b0;
    w_nxt_done      = 1'b0;
    w_nxt_r_addr    = 3'd0;
    w_nxt_en_A      = 1'b0;
    w_nxt_en_B      = 1'b0;
    w_nxt_sel_A     = 1'b0;
    w_nxt_shift_op  = 2'b00;
    w_nxt_ALU_op    = 2'b00;
    w_nxt_en_C      = 1'b0;
    w_nxt_en_status = 1'b0;
    w_nxt_wb_sel    = 2'b00;
    w_nxt_w_addr    = 3'd0;
    w_nxt_w_en      = 1'b0;
    case (w_nxt_state)
      S_IDLE:   w_nxt_ready = 1'b1;
      S_GET_A: begin
        w_nxt_r_addr = w_rn;
        w_nxt_en_A   = 1'b1;
      end
      S_GET_B: begin
        w_nxt_r_addr = w_rm;
        w_nxt_en_B   = 1'b1;
      end
      S_EXEC: begin
        w_nxt_shift_op  = w_sh;
        w_nxt_sel_A     = w_is_mov_reg;
        w_nxt_ALU_op    = w_is_mov_reg ? 2'b00 : w_op;
        w_nxt_en_status = w_is_cmp;
        w_nxt_en_C      = !w_is_cmp;
      end
      S_WRITE_REG: begin
        w_nxt_wb_sel = C_WB_C;
        w_nxt_w_addr = w_rd;
        w_nxt_w_en   = 1'b1;
      end
      S_WRITE_IMM: begin
        w_nxt_wb_sel = C_WB_IMM8;
        w_nxt_w_addr = w_rn;
        w_nxt_w_en   = 1'b1;
      end
      S_DONE:   w_nxt_done = 1'b1;
      default:  w_nxt_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ir      <= 16'h0000;
      illegal   <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
      r_addr    <= 3'd0;
      en_A      <= 1'b0;
      en_B      <= 1'b0;
      sel_A     <= 1'b0;
      shift_op  <= 2'b00;
      ALU_op    <= 2'b00;
      en_C      <= 1'b0;
      en_status <= 1'b0;
      wb_sel    <= 2'b00;
      w_addr    <= 3'd0;
      w_en      <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      ready     <= w_nxt_ready;
      done      <= w_nxt_done;
      r_addr    <= w_nxt_r_addr;
      en_A      <= w_nxt_en_A;
      en_B      <= w_nxt_en_B;
      sel_A     <= w_nxt_sel_A;
      shift_op  <= w_nxt_shift_op;
      ALU_op    <= w_nxt_ALU_op;
      en_C      <= w_nxt_en_C;
      en_status <= w_nxt_en_status;
      wb_sel    <= w_nxt_wb_sel;
      w_addr    <= w_nxt_w_addr;
      w_en      <= w_nxt_w_en;
      if (w_accept) begin
        r_ir    <= instr;
        illegal <= 1'b0;
      end else if ((r_state == S_DECODE) && !w_legal) begin
        illegal <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
